instr_fetch_unit: RTL and testbench

//  Fetch-side initiator for the 512-byte instruction ROM. Drives the 9-bit byte address, captures the 32-bit word,
//  and buffers {pc, instr} pairs in a small prefetch FIFO toward decode. Decode side uses a valid/ready handshake.

---
 rtl/instr_fetch_unit_pkg.sv | 14 +
 rtl/instr_fetch_unit_fetch_fifo.sv | 53 +++++
 rtl/instr_fetch_unit.sv | 102 ++++++++++
 tb/tb_instr_fetch_unit.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch definitions: default widths, word size, reset PC and FSM state encodings.
package instr_fetch_unit_pkg;

   localparam int ADDR_W_DEF   = 9;
   localparam int DATA_W_DEF   = 32;
   localparam int WORD_BYTES   = 4;
   localparam int RESET_PC_DEF = 0;

   typedef enum logic [0:0] {
      ST_FETCH = 1'b0,
      ST_HALT  = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Prefetch FIFO with fall-through head: the entry at the read pointer is always on dout.
module fetch_fifo #(
   parameter int W     = 41,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] cnt;

   assign dout  = mem[rd_ptr];
   assign full  = (cnt == CW'(DEPTH));
   assign empty = (cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage is data only; occupancy is tracked by cnt, so no reset is needed here.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch initiator: PC register, redirect/push arbitration and prefetch FIFO toward decode.
// Optional misaligned-redirect fault and HALT state are enabled with macro FETCH_ALIGN_CHECK_EN.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int          ADDR_W   = ADDR_W_DEF,
   parameter int          DATA_W   = DATA_W_DEF,
   parameter int          DEPTH    = 2,
   parameter int unsigned RESET_PC = RESET_PC_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_instr,
   output logic [ADDR_W-1:0] out_pc,
   output logic              fault
);

   localparam int EW = ADDR_W + DATA_W;

   logic [ADDR_W-1:0] pc;
   fetch_state_t      state;
   logic              fault_q;
   logic              fifo_full, fifo_empty;
   logic              push, pop, misaligned;
   logic [EW-1:0]     head;
   logic [ADDR_W-1:0] tgt;
   logic [ADDR_W-1:0] hold_pc_p1;
   logic [DATA_W-1:0] hold_instr_p1;

   function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] cur);
      return cur + ADDR_W'(WORD_BYTES);
   endfunction

   assign rom_addr  = pc;
   assign out_valid = !fifo_empty;
   assign pop       = out_valid && out_ready;
   // A full FIFO can still accept the new word when the head leaves on the same edge.
   assign push      = en && (state == ST_FETCH) && !redirect_valid && (!fifo_full || pop);
   assign fault     = fault_q;

`ifdef FETCH_ALIGN_CHECK_EN
   assign tgt        = redirect_pc;
   assign misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
   assign tgt        = redirect_pc & ~ADDR_W'(WORD_BYTES - 1);
   assign misaligned = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc      <= ADDR_W'(RESET_PC);
         state   <= ST_FETCH;
         fault_q <= 1'b0;
      end else begin
         if (redirect_valid)
            pc <= tgt;
         else if (push)
            pc <= next_pc(pc);
         if (misaligned) begin
            state   <= ST_HALT;
            fault_q <= 1'b1;
         end
      end
   end

   fetch_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .din   ({pc, rom_data}),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Last head seen, so the outputs stay put while the FIFO is empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_pc_p1    <= '0;
         hold_instr_p1 <= '0;
      end else if (out_valid) begin
         hold_pc_p1    <= head[EW-1:DATA_W];
         hold_instr_p1 <= head[DATA_W-1:0];
      end
   end

   assign out_pc    = out_valid ? head[EW-1:DATA_W] : hold_pc_p1;
   assign out_instr = out_valid ? head[DATA_W-1:0]  : hold_instr_p1;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a combinational ROM model held inside the bench.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic [8:0]  rom_addr;
   logic [31:0] rom_data;
   logic        redirect_valid = 1'b0;
   logic [8:0]  redirect_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [8:0]  out_pc;
   logic        fault;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [8:0] a);
      case (a)
         9'd0:    return 32'h11111111;
         9'd4:    return 32'h22222222;
         9'd8:    return 32'h33333333;
         default: return 32'hC0DE0000 | {23'b0, a};
      endcase
   endfunction

   assign rom_data = rom_word(rom_addr);

   instr_fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .en             (en),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .fault          (fault)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      en = 1'b0; out_ready = 1'b1; rst_n = 1'b0;
      #3;
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", out_valid); end
      n_cmp++; if (out_pc !== 9'd0) begin n_fail++; $display("FAIL rst_pc got %0d want 0", out_pc); end
      n_cmp++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr got %h want 0", out_instr); end
      n_cmp++; if (fault !== 1'b0) begin n_fail++; $display("FAIL rst_fault got %b want 0", fault); end
      tick();
      rst_n = 1'b1;
      tick(); tick();
      n_cmp++; if (out_valid !== 1'b0 || rom_addr !== 9'd0) begin n_fail++; $display("FAIL en0_freeze got v=%b a=%0d want v=0 a=0", out_valid, rom_addr); end
      en = 1'b1;
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 9'd0 || out_instr !== 32'h11111111) begin n_fail++; $display("FAIL seq0 got v=%b pc=%0d i=%h want v=1 pc=0 i=11111111", out_valid, out_pc, out_instr); end
      tick();
      n_cmp++; if (out_pc !== 9'd4 || out_instr !== 32'h22222222) begin n_fail++; $display("FAIL seq4 got pc=%0d i=%h want pc=4 i=22222222", out_pc, out_instr); end
      tick();
      n_cmp++; if (out_pc !== 9'd8 || out_instr !== 32'h33333333) begin n_fail++; $display("FAIL seq8 got pc=%0d i=%h want pc=8 i=33333333", out_pc, out_instr); end
   endtask

   task automatic test_stall();
      out_ready = 1'b0; en = 1'b1;
      do_reset();
      tick(); tick();
      n_cmp++; if (out_valid !== 1'b1 || rom_addr !== 9'd8) begin n_fail++; $display("FAIL stall_full got v=%b a=%0d want v=1 a=8", out_valid, rom_addr); end
      tick(); tick(); tick();
      n_cmp++; if (rom_addr !== 9'd8 || out_pc !== 9'd0) begin n_fail++; $display("FAIL stall_hold got a=%0d pc=%0d want a=8 pc=0", rom_addr, out_pc); end
      out_ready = 1'b1;
      tick();
      n_cmp++; if (out_pc !== 9'd4 || out_instr !== 32'h22222222) begin n_fail++; $display("FAIL drain4 got pc=%0d i=%h want pc=4 i=22222222", out_pc, out_instr); end
      tick();
      n_cmp++; if (out_pc !== 9'd8 || out_instr !== 32'h33333333) begin n_fail++; $display("FAIL drain8 got pc=%0d i=%h want pc=8 i=33333333", out_pc, out_instr); end
      tick();
      n_cmp++; if (out_pc !== 9'd12 || out_instr !== 32'hC0DE000C) begin n_fail++; $display("FAIL drain12 got pc=%0d i=%h want pc=12 i=c0de000c", out_pc, out_instr); end
   endtask

   task automatic test_redirect_full();
      out_ready = 1'b0; en = 1'b1;
      do_reset();
      tick(); tick();
      redirect_valid = 1'b1; redirect_pc = 9'd100;
      tick();
      redirect_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b0 || rom_addr !== 9'd100) begin n_fail++; $display("FAIL redir_flush got v=%b a=%0d want v=0 a=100", out_valid, rom_addr); end
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 9'd100 || out_instr !== 32'hC0DE0064) begin n_fail++; $display("FAIL redir_target got v=%b pc=%0d i=%h want v=1 pc=100 i=c0de0064", out_valid, out_pc, out_instr); end
   endtask

   task automatic test_wrap();
      out_ready = 1'b1;
      redirect_valid = 1'b1; redirect_pc = 9'd508;
      tick();
      redirect_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_flush got v=%b want 0", out_valid); end
      tick();
      n_cmp++; if (out_pc !== 9'd508 || out_instr !== 32'hC0DE01FC) begin n_fail++; $display("FAIL wrap508 got pc=%0d i=%h want pc=508 i=c0de01fc", out_pc, out_instr); end
      tick();
      n_cmp++; if (out_pc !== 9'd0 || out_instr !== 32'h11111111) begin n_fail++; $display("FAIL wrap0 got pc=%0d i=%h want pc=0 i=11111111", out_pc, out_instr); end
      tick();
      n_cmp++; if (out_pc !== 9'd4 || fault !== 1'b0) begin n_fail++; $display("FAIL wrap4 got pc=%0d f=%b want pc=4 f=0", out_pc, fault); end
   endtask

   task automatic test_misaligned();
      out_ready = 1'b1;
      redirect_valid = 1'b1; redirect_pc = 9'd102;
      tick();
      redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      n_cmp++; if (fault !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mis_fault got f=%b v=%b want f=1 v=0", fault, out_valid); end
      tick(); tick();
      n_cmp++; if (out_valid !== 1'b0 || fault !== 1'b1 || rom_addr !== 9'd102) begin n_fail++; $display("FAIL mis_halt got v=%b f=%b a=%0d want v=0 f=1 a=102", out_valid, fault, rom_addr); end
      do_reset();
      n_cmp++; if (fault !== 1'b0) begin n_fail++; $display("FAIL mis_clear got f=%b want 0", fault); end
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 9'd0) begin n_fail++; $display("FAIL mis_resume got v=%b pc=%0d want v=1 pc=0", out_valid, out_pc); end
`else
      n_cmp++; if (fault !== 1'b0 || out_valid !== 1'b0 || rom_addr !== 9'd100) begin n_fail++; $display("FAIL mis_align got f=%b v=%b a=%0d want f=0 v=0 a=100", fault, out_valid, rom_addr); end
      tick();
      n_cmp++; if (out_pc !== 9'd100 || out_instr !== 32'hC0DE0064 || fault !== 1'b0) begin n_fail++; $display("FAIL mis_target got pc=%0d i=%h f=%b want pc=100 i=c0de0064 f=0", out_pc, out_instr, fault); end
`endif
   endtask

   task automatic test_async_reset();
      out_ready = 1'b1; en = 1'b1;
      do_reset();
      tick(); tick();
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 9'd4) begin n_fail++; $display("FAIL pre_areset got v=%b pc=%0d want v=1 pc=4", out_valid, out_pc); end
      #3;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0 || out_pc !== 9'd0 || out_instr !== 32'h0) begin n_fail++; $display("FAIL areset got v=%b pc=%0d i=%h want v=0 pc=0 i=0", out_valid, out_pc, out_instr); end
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_stall();
      test_redirect_full();
      test_wrap();
      test_misaligned();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
